// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: state encoding and bus widths.
package branch_redirect_ctrl_pkg;

  // Width of PC / target addresses on the fetch bus.
  localparam int unsigned BRC_ADDR_WIDTH = 32;

  // Controller state: which of (redirect, delay slot) are still outstanding.
  typedef enum logic [1:0] {
    BRC_IDLE       = 2'd0,
    BRC_REDIR_SLOT = 2'd1,
    BRC_SLOT       = 2'd2,
    BRC_REDIR      = 2'd3
  } brc_state_e;

  // True when the delay-slot instruction has not yet left ID.
  function automatic logic brc_slot_pending(input brc_state_e s);
    return (s == BRC_REDIR_SLOT) || (s == BRC_SLOT);
  endfunction

  // True when fetch has not yet consumed the redirect.
  function automatic logic brc_redir_pending(input brc_state_e s);
    return (s == BRC_REDIR_SLOT) || (s == BRC_REDIR);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: launches the ID-stage branch redirect toward the PC
// unit, holds it until fetch accepts it, and tracks the architectural delay slot.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BRC_ADDR_WIDTH
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_stall,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  fetch_ready,
  input  logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  in_delay_slot,
  output logic                  busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  taken_count,
  output logic [CNT_WIDTH-1:0]  redirect_stall_count
`endif
);

  brc_state_e            state_q;
  brc_state_e            state_d;
  logic [ADDR_WIDTH-1:0] target_q;
  logic [ADDR_WIDTH-1:0] target_d;

  logic slot_pending;
  logic redir_pending;
  logic slot_leave;
  logic accept;

  // A branch sitting in the delay slot is ignored, hence the slot_pending term.
  assign slot_pending  = brc_slot_pending(state_q);
  assign redir_pending = brc_redir_pending(state_q);
  assign slot_leave    = slot_pending & id_valid & ~id_stall;
  assign accept        = id_valid & ~id_stall & branch_flag & ~flush & ~slot_pending;

  // State and target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BRC_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (flush) begin
      state_d  = BRC_IDLE;
      target_d = '0;
    end else begin
      if (accept) begin
        target_d = branch_addr;
      end
      unique case (state_q)
        BRC_IDLE, BRC_REDIR: begin
          if (accept) begin
            state_d = fetch_ready ? BRC_SLOT : BRC_REDIR_SLOT;
          end else if ((state_q == BRC_REDIR) && fetch_ready) begin
            state_d = BRC_IDLE;
          end
        end
        BRC_REDIR_SLOT: begin
          if (fetch_ready && slot_leave) begin
            state_d = BRC_IDLE;
          end else if (fetch_ready) begin
            state_d = BRC_SLOT;
          end else if (slot_leave) begin
            state_d = BRC_REDIR;
          end
        end
        BRC_SLOT: begin
          if (slot_leave) begin
            state_d = BRC_IDLE;
          end
        end
        default: state_d = BRC_IDLE;
      endcase
    end
  end

  // Outputs; the redirect is visible in the accept cycle itself, address is zero when idle.
  always_comb begin
    redirect_valid = ~flush & (accept | redir_pending);
    redirect_addr  = '0;
    if (redirect_valid) begin
      redirect_addr = redir_pending ? target_q : branch_addr;
    end
    in_delay_slot  = slot_pending & id_valid;
    busy           = (state_q != BRC_IDLE);
  end

`ifdef BRANCH_STATS_EN
  logic stall_inc;
  assign stall_inc = redirect_valid & ~fetch_ready;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (taken_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (redirect_stall_count)
  );
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed scenarios then random traffic,
// checked against a pending-flag reference model.
module tb_branch_redirect_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_stall, branch_flag, fetch_ready, flush;
  logic [AW-1:0] branch_addr;
  logic          redirect_valid, in_delay_slot, busy;
  logic [AW-1:0] redirect_addr;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] taken_count, redirect_stall_count;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .ADDR_WIDTH (AW)
`ifdef BRANCH_STATS_EN
    , .CNT_WIDTH (CW)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .branch_flag    (branch_flag),
    .branch_addr    (branch_addr),
    .fetch_ready    (fetch_ready),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .in_delay_slot  (in_delay_slot),
    .busy           (busy)
`ifdef BRANCH_STATS_EN
    , .taken_count          (taken_count)
    , .redirect_stall_count (redirect_stall_count)
`endif
  );

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          ids;
    logic          bsy;
    int unsigned   tc;
    int unsigned   sc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: two outstanding-work flags plus the saved target.
  logic          m_slot, m_redir;
  logic [AW-1:0] m_target;
  int unsigned   m_tc, m_sc;
  localparam int unsigned SAT = (1 << CW) - 1;

  function automatic logic m_accept();
    return id_valid & ~id_stall & branch_flag & ~flush & ~m_slot;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clock();
    logic acc, rv;
    acc = m_accept();
    rv  = ~flush & (acc | m_redir);
    if (rst) begin
      m_tc = 0;
      m_sc = 0;
    end else begin
      if (acc && m_tc < SAT) m_tc++;
      if (rv && !fetch_ready && m_sc < SAT) m_sc++;
    end
    if (rst || flush) begin
      m_slot = 1'b0; m_redir = 1'b0; m_target = '0;
    end else if (acc) begin
      m_slot   = 1'b1;
      m_redir  = ~fetch_ready;
      m_target = branch_addr;
    end else begin
      if (m_slot && id_valid && !id_stall) m_slot = 1'b0;
      if (m_redir && fetch_ready) m_redir = 1'b0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rv  = ~flush & (m_accept() | m_redir);
    e.ra  = !e.rv ? '0 : (m_redir ? m_target : branch_addr);
    e.ids = m_slot & id_valid;
    e.bsy = m_slot | m_redir;
    e.tc  = m_tc;
    e.sc  = m_sc;
    return e;
  endfunction

  // One cycle of stimulus: clock the model, apply inputs, queue the expected response.
  task automatic step(input logic r, input logic v, input logic st, input logic bf,
                      input logic [AW-1:0] a, input logic fr, input logic fl);
    @(posedge clk);
    model_clock();
    #1;
    rst = r; id_valid = v; id_stall = st; branch_flag = bf;
    branch_addr = a; fetch_ready = fr; flush = fl;
    #0;
    q.push_back(model_out());
  endtask

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("redirect_valid", AW'(redirect_valid), AW'(e.rv));
      chk("redirect_addr",  redirect_addr,       e.ra);
      chk("in_delay_slot",  AW'(in_delay_slot),  AW'(e.ids));
      chk("busy",           AW'(busy),           AW'(e.bsy));
`ifdef BRANCH_STATS_EN
      chk("taken_count",          AW'(taken_count),          AW'(e.tc));
      chk("redirect_stall_count", AW'(redirect_stall_count), AW'(e.sc));
`endif
    end
  end

  localparam logic [AW-1:0] T1 = 32'h0040_0020;
  localparam logic [AW-1:0] T2 = 32'h0040_0100;

  initial begin
    rst = 1'b1; id_valid = 0; id_stall = 0; branch_flag = 0;
    branch_addr = '0; fetch_ready = 0; flush = 0;
    m_slot = 0; m_redir = 0; m_target = '0; m_tc = 0; m_sc = 0;
    repeat (3) step(1, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0);

    // Immediate redirect, delay slot marked, then idle.
    step(0, 1, 0, 1, T1, 1, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0);

    // Redirect held across fetch back-pressure, target stable after branch_addr changes.
    step(0, 1, 0, 1, T1, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, '0, 1, 0);
    step(0, 0, 0, 0, '0, 0, 0);

    // Stalled branch not committed until the stall drops.
    step(0, 1, 1, 1, T1, 1, 0);
    step(0, 1, 1, 1, T1, 1, 0);
    step(0, 1, 0, 1, T1, 1, 0);
    // Branch in the delay slot is ignored.
    step(0, 1, 0, 1, T2, 1, 0);
    step(0, 1, 0, 0, '0, 1, 0);

    // Flush while redirect and slot pending, then flush coincident with accept.
    step(0, 1, 0, 1, T1, 0, 0);
    step(0, 0, 0, 0, '0, 0, 1);
    step(0, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 1, T2, 1, 1);
    step(0, 0, 0, 0, '0, 0, 0);

    // Branch accepted while a bare redirect is outstanding.
    step(0, 1, 0, 1, T1, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 1, 0, 1, T2, 0, 0);
    step(0, 1, 0, 0, '0, 1, 0);
    step(0, 1, 0, 0, '0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 3,
           AW'($urandom),
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0);
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
